// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate truth-table self-test stage.
//   - op_t and the gate function encodings (OP_AND .. OP_XNOR); 6 and 7 are illegal
//   - VEC_COUNT: number of input vectors applied per run
//   - state_e: FSM state encoding of the checker
package gate_truth_checker_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NAND = 3'd2;
  localparam op_t OP_NOR  = 3'd3;
  localparam op_t OP_XOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;

  localparam int unsigned VEC_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Control/result bundle of the gate truth checker.
//   master: the requester -- drives start/op, observes the run status/result
//   slave : the checker  -- consumes start/op, drives busy/done/pass/fail_vec/op_err
interface gate_truth_checker_if;
  import gate_truth_checker_pkg::*;

  logic       start;
  op_t        op;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic       op_err;

  modport master (
    output start, op,
    input  busy, done, pass, fail_vec, op_err
  );

  modport slave (
    input  start, op,
    output busy, done, pass, fail_vec, op_err
  );
endinterface

// File: rtl/gate_truth_checker_ref_model.sv
// gate_ref_model: combinational truth-table reference for one 2-input gate.
//   op      : gate function encoding
//   a, b    : gate inputs
//   y_exp   : expected gate output (0 when op is illegal)
//   illegal : op is not one of the six defined functions
module gate_ref_model
  import gate_truth_checker_pkg::*;
(
  input  op_t  op,
  input  logic a,
  input  logic b,
  output logic y_exp,
  output logic illegal
);

  always_comb begin
    y_exp   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_NAND: y_exp = ~(a & b);
      OP_NOR:  y_exp = ~(a | b);
      OP_XOR:  y_exp = a ^ b;
      OP_XNOR: y_exp = ~(a ^ b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives a 2-input gate through all four input vectors,
// samples its output and compares against the selected gate function.
//   clk, rst_n : clock, asynchronous active-low reset
//   ctl        : start/op request and busy/done/pass/fail_vec/op_err result
//   a_o, b_o   : registered drive of the gate inputs (vector i: a=i[0], b=i[1])
//   y_i        : gate output, same clock domain
// SETTLE_CYCLES (0..15) idle cycles separate applying a vector and sampling y_i.
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_truth_checker_if.slave  ctl,
  output logic                 a_o,
  output logic                 b_o,
  input  logic                 y_i
);

  // Settle counter counts down SETTLE_CYCLES-1 .. 0; unused when SETTLE_CYCLES is 0.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX    = 2'(VEC_COUNT - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  op_t        op_q, op_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       err_q, err_d;

  op_t  ref_op;
  logic y_exp;
  logic illegal;

  // In IDLE the model judges the incoming op for legality; during a run it
  // evaluates the latched op at the current vector.
  assign ref_op = (state_q == ST_IDLE) ? ctl.op : op_q;

  gate_ref_model u_ref (
    .op      (ref_op),
    .a       (idx_q[0]),
    .b       (idx_q[1]),
    .y_exp   (y_exp),
    .illegal (illegal)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (ctl.start) begin
          op_d   = ctl.op;
          idx_d  = 2'd0;
          fail_d = 4'h0;
          pass_d = 1'b0;
          err_d  = 1'b0;
          if (illegal) begin
            err_d   = 1'b1;
            fail_d  = 4'hF;
            state_d = ST_DONE;
          end else begin
            state_d = ST_APPLY;
          end
        end
      end

      ST_APPLY: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end

      ST_SAMPLE: begin
        if (y_i != y_exp) fail_d[idx_q] = 1'b1;
        if (idx_q == LAST_IDX) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (fail_d == 4'h0) && !err_q;
          state_d = ST_DONE;
        end else begin
          // Gate inputs are registered on the edge into APPLY so they are
          // already stable during APPLY and held through SAMPLE.
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[0];
          b_d     = idx_d[1];
          state_d = ST_APPLY;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      op_q    <= OP_AND;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      fail_q  <= 4'h0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign a_o          = a_q;
  assign b_o          = b_q;
  assign ctl.busy     = (state_q != ST_IDLE);
  assign ctl.done     = (state_q == ST_DONE);
  assign ctl.pass     = pass_q;
  assign ctl.fail_vec = fail_q;
  assign ctl.op_err   = err_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE_CYCLES=2 and 0), each
// wired to a gate modelled as a 4-entry truth table indexed by {b,a}.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  gate_truth_checker_if ifs ();
  gate_truth_checker_if ifz ();

  logic       a_s, b_s, y_s, a_z, b_z, y_z;
  logic [3:0] tt_s, tt_z;

  assign y_s = tt_s[{b_s, a_s}];
  assign y_z = tt_z[{b_z, a_z}];

  gate_truth_checker #(.SETTLE_CYCLES(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .ctl(ifs), .a_o(a_s), .b_o(b_s), .y_i(y_s)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .ctl(ifz), .a_o(a_z), .b_o(b_z), .y_i(y_z)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit         z;
    logic [2:0] op;
    logic [3:0] tt;
    logic [3:0] exp_fail;
    bit         exp_pass;
    bit         exp_err;
    string      name;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Truth table of each function as a nibble, bit i = f(a=i[0], b=i[1]).
  function automatic logic [3:0] op_tt(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic drive(input bit z, input logic start, input logic [2:0] op);
    if (z) begin ifz.start = start; ifz.op = op; end
    else   begin ifs.start = start; ifs.op = op; end
  endtask

  task automatic get(input bit z, output logic busy, output logic done, output logic pass,
                     output logic err, output logic a, output logic b, output logic [3:0] fv);
    busy = z ? ifz.busy     : ifs.busy;
    done = z ? ifz.done     : ifs.done;
    pass = z ? ifz.pass     : ifs.pass;
    err  = z ? ifz.op_err   : ifs.op_err;
    a    = z ? a_z          : a_s;
    b    = z ? b_z          : b_s;
    fv   = z ? ifz.fail_vec : ifs.fail_vec;
  endtask

  task automatic chk_zero(input bit z, input string tag);
    logic busy, done, pass, err, a, b;
    logic [3:0] fv;
    get(z, busy, done, pass, err, a, b, fv);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"},  err,  0);
    chk({tag, "_a"},    a,    0);
    chk({tag, "_b"},    b,    0);
    chk({tag, "_fv"},   fv,   0);
  endtask

  // One complete run from an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run(input bit z, input logic [2:0] op, input logic [3:0] tt,
                     input logic [3:0] ef, input bit ep, input bit eerr, input string name);
    int s  = z ? 0 : 2;
    int dk = eerr ? 1 : 1 + 4 * (s + 2);
    logic busy, done, pass, err, a, b;
    logic [3:0] fv;
    if (z) tt_z = tt; else tt_s = tt;
    drive(z, 1'b1, op);
    @(posedge clk); #1;
    // op wiggling mid-run must not affect the result
    drive(z, 1'b0, 3'($urandom_range(0, 7)));
    for (int k = 1; k <= dk + 1; k++) begin
      get(z, busy, done, pass, err, a, b, fv);
      if (k < dk) begin
        int v = (k - 1) / (s + 2);
        chk({name, "_done_early"}, done, 0);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_a"}, a, v[0]);
        chk({name, "_b"}, b, v[1]);
      end else if (k == dk) begin
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_done"}, busy, 1);
        chk({name, "_a_done"}, a, 0);
        chk({name, "_b_done"}, b, 0);
        chk({name, "_fail_vec"}, fv, ef);
        chk({name, "_pass"}, pass, ep);
        chk({name, "_op_err"}, err, eerr);
      end else begin
        chk({name, "_done_after"}, done, 0);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_pass_hold"}, pass, ep);
        chk({name, "_fv_hold"}, fv, ef);
      end
      if (k <= dk) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ef;
    bit legal;
    int last, nd;

    tbl[0] = '{1'b0, 3'd0, 4'h8, 4'b0000, 1'b1, 1'b0, "and_golden"};
    tbl[1] = '{1'b0, 3'd1, 4'h8, 4'b0110, 1'b0, 1'b0, "or_on_and"};
    tbl[2] = '{1'b0, 3'd0, 4'hF, 4'b0111, 1'b0, 1'b0, "stuck1"};
    tbl[3] = '{1'b0, 3'd6, 4'h8, 4'b1111, 1'b0, 1'b1, "illegal6"};
    tbl[4] = '{1'b0, 3'd7, 4'h8, 4'b1111, 1'b0, 1'b1, "illegal7"};
    tbl[5] = '{1'b0, 3'd4, 4'h6, 4'b0000, 1'b1, 1'b0, "xor_golden"};
    tbl[6] = '{1'b0, 3'd3, 4'h0, 4'b0001, 1'b0, 1'b0, "nor_stuck0"};
    tbl[7] = '{1'b1, 3'd0, 4'h8, 4'b0000, 1'b1, 1'b0, "and_s0"};
    tbl[8] = '{1'b1, 3'd5, 4'h9, 4'b0000, 1'b1, 1'b0, "xnor_s0"};
    tbl[9] = '{1'b1, 3'd2, 4'h8, 4'b1111, 1'b0, 1'b0, "nand_on_and_s0"};

    rst_n = 1'b0;
    tt_s = 4'h8; tt_z = 4'h8;
    drive(1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero(1'b0, "reset_s");
    chk_zero(1'b1, "reset_z");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run(tbl[i].z, tbl[i].op, tbl[i].tt, tbl[i].exp_fail, tbl[i].exp_pass,
          tbl[i].exp_err, tbl[i].name);

    for (int r = 0; r < 16; r++) begin
      bit         z  = 1'($urandom_range(0, 1));
      logic [2:0] op = 3'($urandom_range(0, 7));
      logic [3:0] tt = 4'($urandom_range(0, 15));
      legal = (op <= 3'd5);
      ef    = legal ? (op_tt(op) ^ tt) : 4'hF;
      run(z, op, tt, ef, legal && (ef == 4'h0), !legal, "rand");
    end

    // Reset abort during SETTLE of vector 2 (cycle T0+10)
    tt_s = 4'hF;
    drive(1'b0, 1'b1, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_fv", ifs.fail_vec, 4'b0011);
    chk("abort_pre_busy", ifs.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero(1'b0, "abort");
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", ifs.done, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 3'd0, 4'h8, 4'b0000, 1'b1, 1'b0, "after_reset");

    // Back-to-back runs with start held, SETTLE_CYCLES=0
    tt_z = 4'h8;
    drive(1'b1, 1'b1, 3'd0);
    last = -1;
    nd   = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (ifz.done) begin
        chk("b2b_pass", ifz.pass, 1);
        chk("b2b_fv", ifz.fail_vec, 0);
        if (last >= 0) chk("b2b_period", c - last, 10);
        last = c;
        nd++;
      end
    end
    chk("b2b_count", nd, 4);
    drive(1'b1, 1'b0, 3'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_idle_busy", ifz.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
